// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the single-beat AXI SRAM read slave.
// Holds the FSM encoding, AXI response codes and default parameters.
package axi_sram_pkg;

    localparam int          ADDR_W_DEF    = 32;
    localparam int          DATA_W_DEF    = 64;
    localparam int          ID_W_DEF      = 4;
    localparam logic [31:0] RAM_BYTES_DEF = 32'h0001_0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        RESP
    } state_t;

endpackage

// File: rtl/axi_rd_addr_chk.sv
// Combinational legality check for an incoming AR: range, size, alignment.
// Only instantiated when AXI_RD_ERR_CHK_EN is defined.
module axi_rd_addr_chk
    import axi_sram_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] RAM_BYTES = RAM_BYTES_DEF
) (
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arsize,
    output logic              err
);

    logic [2:0] w_mask;

    always_comb begin
        w_mask = 3'b000;
        case (arsize)
            3'd1:    w_mask = 3'b001;
            3'd2:    w_mask = 3'b011;
            3'd3:    w_mask = 3'b111;
            default: w_mask = 3'b000;
        endcase
    end

    assign err = (araddr >= ADDR_W'(RAM_BYTES))
               | (arsize > 3'd3)
               | (|(araddr[2:0] & w_mask));

endmodule

// File: rtl/axi_sram_rd_slave.sv
// Single-beat AXI read responder in front of a 1-cycle-latency SRAM.
// Define AXI_RD_ERR_CHK_EN to reject illegal ARs with SLVERR.
module axi_sram_rd_slave
    import axi_sram_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          ID_W      = ID_W_DEF,
    parameter logic [31:0] RAM_BYTES = RAM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              w_ar_hs;
    logic              w_unused;

`ifdef AXI_RD_ERR_CHK_EN
    logic w_err;

    axi_rd_addr_chk #(
        .ADDR_W    (ADDR_W),
        .RAM_BYTES (RAM_BYTES)
    ) u_chk (
        .araddr (araddr),
        .arsize (arsize),
        .err    (w_err)
    );
`endif

    // Latched size and sub-word address bits are kept for visibility only.
    assign w_unused = ^{r_addr[2:0], r_size, RAM_BYTES[0]};
    assign w_ar_hs  = arvalid & arready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_ar_hs) begin
`ifdef AXI_RD_ERR_CHK_EN
                    w_next = w_err ? RESP : REQ;
`else
                    w_next = REQ;
`endif
                end
            end
            REQ:     w_next = DATA;
            DATA:    w_next = RESP;
            RESP:    if (rready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        arready   = 1'b0;
        ram_ren   = 1'b0;
        ram_raddr = '0;
        rvalid    = 1'b0;
        unique case (r_state)
            IDLE: arready = ~reset;
            REQ: begin
                ram_ren   = 1'b1;
                ram_raddr = {r_addr[ADDR_W-1:3], 3'b000};
            end
            RESP:    rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_id   <= arid;
                        r_addr <= araddr;
                        r_size <= arsize;
`ifdef AXI_RD_ERR_CHK_EN
                        if (w_err) begin
                            r_rdata <= '0;
                            r_rresp <= RESP_SLVERR;
                        end
`endif
                    end
                end
                DATA: begin
                    r_rdata <= ram_rdata;
                    r_rresp <= RESP_OKAY;
                end
                default: ;
            endcase
        end
    end

    assign rid   = r_id;
    assign rdata = r_rdata;
    assign rresp = r_rresp;
    assign rlast = rvalid;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Directed bench for axi_sram_rd_slave with an SRAM model and a scoreboard.
// Build with AXI_RD_ERR_CHK_EN defined to exercise the SLVERR path.
module tb_axi_sram_rd_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [2:0]  arsize = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        ram_ren;
    logic [31:0] ram_raddr;
    logic [63:0] ram_rdata = '0;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        int          lat;
        int          ren;
        logic [31:0] raddr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          ren_cnt = 0;
    int          ren_base = 0;
    logic [31:0] last_raddr = '0;

    axi_sram_rd_slave dut (
        .clk       (clk),
        .reset     (reset),
        .arid      (arid),
        .araddr    (araddr),
        .arsize    (arsize),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sram_word(input logic [31:0] a);
        return {32'hC0DE_0000 ^ a, ~a};
    endfunction

    always @(posedge clk) begin
        if (ram_ren) begin
            ram_rdata  <= sram_word(ram_raddr);
            last_raddr <= ram_raddr;
            ren_cnt    <= ren_cnt + 1;
        end
    end

    function automatic bit model_err(input logic [31:0] a,
                                     input logic [2:0] sz);
`ifdef AXI_RD_ERR_CHK_EN
        logic [2:0] m;
        m = (sz == 3'd1) ? 3'b001 :
            (sz == 3'd2) ? 3'b011 :
            (sz == 3'd3) ? 3'b111 : 3'b000;
        return (a >= 32'h0001_0000) || (sz > 3'd3) || ((a[2:0] & m) != 0);
`else
        return (a[31:0] != a[31:0]);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive an AR, wait (bounded) for arready, and push the expected R beat.
    task automatic issue(input logic [3:0] id, input logic [31:0] a,
                         input logic [2:0] sz, output int waits);
        exp_t e;
        bit   err;
        arid    = id;
        araddr  = a;
        arsize  = sz;
        arvalid = 1'b1;
        waits   = 0;
        while (!arready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!arready) begin
            chk("ar_timeout", 64'(arready), 64'd1);
            arvalid = 1'b0;
            return;
        end
        ren_base = ren_cnt;
        @(posedge clk); #1;
        arvalid = 1'b0;
        err     = model_err(a, sz);
        e.id    = id;
        e.raddr = {a[31:3], 3'b000};
        e.data  = err ? 64'd0 : sram_word(e.raddr);
        e.resp  = err ? 2'b10 : 2'b00;
        e.lat   = err ? 0 : 2;
        e.ren   = err ? 0 : 1;
        sb.push_back(e);
    endtask

    // Count edges after the AR handshake until rvalid, then score the beat.
    task automatic await_resp(input string tag, output exp_t e);
        int lat;
        lat = 0;
        while (!rvalid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            e = '{default: '0};
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
        chk({tag, "_ren"}, 64'(ren_cnt - ren_base), 64'(e.ren));
        if (e.ren == 1) chk({tag, "_raddr"}, 64'(last_raddr), 64'(e.raddr));
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, "_rlast"}, 64'(rlast), 64'd1);
        chk({tag, "_rid"}, 64'(rid), 64'(e.id));
        chk({tag, "_rdata"}, rdata, e.data);
        chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
    endtask

    task automatic finish_resp(input string tag);
        rready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_done_arready"}, 64'(arready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   w;
        int   base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_ren", 64'(ram_ren), 64'd0);
        chk("rst_raddr", 64'(ram_raddr), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_arready", 64'(arready), 64'd1);

        // Basic read with rready already high.
        rready = 1'b1;
        issue(4'd0, 32'h200, 3'd2, w);
        chk("t1_ren", 64'(ram_ren), 64'd1);
        chk("t1_raddr", 64'(ram_raddr), 64'h200);
        chk("t1_arready", 64'(arready), 64'd0);
        await_resp("t1", e);

        // Back-to-back AR waits for the R handshake.
        chk("t2_busy_arready", 64'(arready), 64'd0);
        issue(4'd0, 32'h4, 3'd2, w);
        chk("t2_waits", 64'(w), 64'd1);
        chk("t2_raddr", 64'(ram_raddr), 64'h0);
        await_resp("t2", e);
        finish_resp("t2");

        // Backpressure: hold rready low for 5 cycles.
        rready = 1'b0;
        issue(4'hA, 32'h1238, 3'd3, w);
        await_resp("t3", e);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                araddr  = 32'h400;
                arsize  = 3'd2;
                arvalid = 1'b1;
            end
            if (i == 3) arvalid = 1'b0;
            @(posedge clk); #1;
            chk("t3_hold_rvalid", 64'(rvalid), 64'd1);
            chk("t3_hold_rdata", rdata, e.data);
            chk("t3_hold_rid", 64'(rid), 64'(e.id));
        end
        base = ren_cnt;
        finish_resp("t3");
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t3_idle_rvalid", 64'(rvalid), 64'd0);
        chk("t3_idle_ren", 64'(ren_cnt - base), 64'd0);

        // Narrow unaligned-by-byte read returns the whole word.
        issue(4'd5, 32'h3F, 3'd0, w);
        await_resp("t4", e);
        finish_resp("t4");

        // Reset while the SRAM data is returning aborts the read.
        issue(4'd3, 32'h100, 3'd3, w);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_rvalid", 64'(rvalid), 64'd0);
        chk("t5_ren", 64'(ram_ren), 64'd0);
        chk("t5_arready", 64'(arready), 64'd0);
        chk("t5_rid", 64'(rid), 64'd0);
        chk("t5_rdata", rdata, 64'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_rel_arready", 64'(arready), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t5_no_resp", 64'(rvalid), 64'd0);
        issue(4'd7, 32'h208, 3'd3, w);
        await_resp("t5b", e);
        finish_resp("t5b");

        // Out-of-range and misaligned ARs.
        issue(4'd1, 32'h0001_0000, 3'd2, w);
        await_resp("t6a", e);
        finish_resp("t6a");
        issue(4'd2, 32'h6, 3'd2, w);
        await_resp("t6b", e);
        finish_resp("t6b");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_sram_rd_slave.md
AXI_SRAM_RD_SLAVE -- requirements
Module: axi_sram_rd_slave

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 64, data width; ID_W, 4, ID width; RAM_BYTES, 32'h0001_0000, SRAM size in bytes.
REQ-002 Ports SHALL be:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- arid  in  ID_W  read ID.
- araddr  in  ADDR_W  byte address.
- arsize  in  3  log2 of bytes per beat.
- arvalid  in  1  address valid.
- arready  out  1  address accepted.
- rid  out  ID_W  response ID.
- rdata  out  DATA_W  read data.
- rresp  out  2  response code.
- rlast  out  1  last beat.
- rvalid  out  1  response valid.
- rready  in  1  response accepted.
- ram_ren  out  1  SRAM read enable.
- ram_raddr  out  ADDR_W  SRAM word-aligned byte address.
- ram_rdata  in  DATA_W  SRAM data, valid one cycle after ram_ren.

Function
REQ-003 The block SHALL be a single-beat AXI read responder with no bursts; rlast SHALL equal rvalid.
REQ-004 The FSM SHALL have four states:
- IDLE: arready=1.
- REQ: ram_ren=1.
- DATA: SRAM data returning.
- RESP: rvalid=1.
REQ-005 In IDLE, when arvalid&arready is high at an edge, the block SHALL latch arid, araddr and arsize, and SHALL move to REQ.
REQ-006 In REQ, ram_raddr SHALL be {addr_q[ADDR_W-1:3],3'b000} and ram_ren SHALL be 1; the next state SHALL be DATA.
REQ-007 ram_ren SHALL be 0 and ram_raddr SHALL be 0 in every state other than REQ.
REQ-008 In DATA, ram_rdata SHALL be registered into rdata, rresp SHALL be set to 2'b00, and the next state SHALL be RESP.
REQ-009 Latency: with the AR handshake at edge N, rvalid SHALL be 1 from edge N+3.
REQ-010 In RESP, rvalid, rid, rdata and rresp SHALL stay stable until rvalid&rready is high at an edge; the block SHALL then return to IDLE with rvalid=0.
REQ-011 arready SHALL be 0 outside IDLE, so at most one transaction is outstanding; a new AR is accepted no earlier than the cycle after the R handshake.
REQ-012 rdata SHALL return the full aligned 64-bit word for every arsize; lane selection is the master's job.
REQ-013 arvalid deasserted before acceptance SHALL have no effect, and no state SHALL change.
REQ-014 rready held high before rvalid SHALL complete the handshake on the first RESP edge.

Reset
REQ-015 reset=1 SHALL asynchronously force IDLE and set all outputs to 0 except arready, which SHALL be 1 once reset=0.
REQ-016 Reset in REQ, DATA or RESP SHALL abort the transaction: no response is issued and rvalid drops immediately.

Configuration
REQ-017 With AXI_RD_ERR_CHK_EN defined, an accepted AR SHALL be rejected when any of these holds: araddr>=RAM_BYTES, arsize>3, or araddr not aligned to 2^arsize.
REQ-018 A rejected AR SHALL go IDLE->RESP directly with ram_ren never asserted, rresp=2'b10 (SLVERR), rdata=0, and rid=latched arid.
REQ-019 Without AXI_RD_ERR_CHK_EN, no checking logic SHALL exist and rresp SHALL always be 2'b00.

Structure
REQ-020 Package axi_sram_pkg SHALL hold:
- the state encoding (IDLE, REQ, DATA, RESP);
- the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants;
- the default parameter values.
REQ-021 The error check SHALL live in sub-module axi_rd_addr_chk (combinational, inputs araddr/arsize, output err), instantiated only under AXI_RD_ERR_CHK_EN.

Verification
REQ-022 AR arid=0, araddr=0x200, arsize=2 with rready=1 -> ram_ren for one cycle with ram_raddr=0x200; rvalid at handshake+3; rdata=SRAM[0x200]; rresp=0; rid=0; rlast=1.
REQ-023 AR araddr=0x4 immediately after the previous read -> arready=0 until the R handshake; then ram_raddr=0x0 and rdata=SRAM word 0x0.
REQ-024 rready=0 for 5 cycles during RESP -> rvalid, rdata and rid stable for all 5 cycles; single completion when rready=1; arready=1 the next cycle.
REQ-025 reset=1 pulsed while in DATA -> rvalid=0, ram_ren=0 and arready=0 immediately; arready=1 after reset=0; the next AR completes normally.
REQ-026 With AXI_RD_ERR_CHK_EN, araddr=0x10000 (arsize=2) and araddr=0x6 (arsize=2) -> rresp=2'b10, rdata=0, ram_ren never asserted, rvalid at handshake+1.
REQ-027 Without the macro, the same two ARs -> rresp=2'b00 with the SRAM accessed.
